// File: rtl/regfile_pkg.sv
// Shared constants and the one-hot register decoder for the register-bank write path.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;
  localparam int IDX_W  = 3;
  // Decoder accepts addresses up to DEC_AW bits; callers keep the low NREGS enables.
  localparam int DEC_AW = 8;
  localparam int DEC_W  = 1 << DEC_AW;

  function automatic logic [DEC_W-1:0] onehot_dec(input logic [DEC_AW-1:0] addr);
    logic [DEC_W-1:0] en;
    en       = '0;
    en[addr] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant among NREQ requesters, combinational from req/stall/pointer.
// The pointer moves to one past the granted requester whenever advance is high.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             stall,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] ptr;
  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;
  logic             found;
  logic [SUM_W-1:0] sum;

  always_comb begin
    // Rotate so the pointer sits at bit 0; the lowest set bit is the winner.
    rot   = stall ? '0 : NREQ'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = IDX_W'(j);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SUM_W'(NREQ)) begin
      sum = sum - SUM_W'(NREQ);
    end
    grant_idx = sum[IDX_W-1:0];
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = found && (sum == SUM_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-bank write port among NREQ writers; one registered write stage (latency 1).
// req_ready is a same-cycle round-robin grant, held low while stall is set; one write per cycle.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     stall,
  output logic [DATA_W-1:0]        wr_data,
  output logic [NREGS-1:0]         wr_enable,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     addr_err,
  output logic [15:0]              wr_count
);

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              transfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              addr_bad;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (reset_n),
    .req       (req_valid),
    .stall     (stall),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign transfer  = |(req_valid & grant);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Out-of-range addresses are consumed but never reach the bank.
  assign addr_bad = 32'(sel_addr) >= 32'(NREGS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_data   <= '0;
      wr_enable <= '0;
      grant_id  <= '0;
      addr_err  <= 1'b0;
      wr_count  <= '0;
    end else begin
      wr_enable <= '0;
      addr_err  <= 1'b0;
      if (transfer) begin
        if (addr_bad) begin
          addr_err <= 1'b1;
        end else begin
          wr_data   <= sel_data;
          wr_enable <= NREGS'(onehot_dec(DEC_AW'(sel_addr)));
          grant_id  <= grant_idx;
          wr_count  <= wr_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter with NREQ=3, NREGS=8: vector table plus hand-written corner sequences.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        stall;
  logic [15:0] wr_data;
  logic [7:0]  wr_enable;
  logic [2:0]  grant_id;
  logic        addr_err;
  logic [15:0] wr_count;

  regfile_write_arbiter #(.NREQ(3), .DATA_W(16), .NREGS(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .wr_data   (wr_data),
    .wr_enable (wr_enable),
    .grant_id  (grant_id),
    .addr_err  (addr_err),
    .wr_count  (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  v;
    logic        st;
    logic [3:0]  a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic [2:0]  rdy;
  } vec_t;

  typedef struct {
    logic [7:0]  en;
    logic [15:0] data;
    logic [2:0]  gid;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  vec_t        tbl [14];
  exp_t        q [$];
  int          total = 0;
  int          bad = 0;
  int          ptr_m = 0;
  logic [15:0] cnt_m = '0;
  logic [15:0] last_data_m = '0;
  logic [2:0]  last_gid_m = '0;
  logic [15:0] bank_m [8];
  logic        bank_w [8];
  logic [15:0] dut_bank [8];
  logic [3:0]  cur_addr [3];
  logic [15:0] cur_data [3];

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) if (wr_enable[i]) dut_bank[i] <= wr_data;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [2:0] model_grant(input logic [2:0] v, input logic st, input int p);
    logic [2:0] g;
    g = '0;
    if (!st) begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (p + k) % 3;
        if (v[j]) begin
          g[j] = 1'b1;
          return g;
        end
      end
    end
    return g;
  endfunction

  task automatic drive(input logic [2:0] v, input logic st);
    req_valid = v;
    stall     = st;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*4 +: 4]   = cur_addr[i];
      req_data[i*16 +: 16] = cur_data[i];
    end
  endtask

  task automatic model_reset();
    ptr_m = 0;
    cnt_m = '0;
    last_data_m = '0;
    last_gid_m = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(3'b000, 1'b0);
    repeat (2) @(negedge clk);
    check("rst wr_enable", 32'(wr_enable), 32'h0);
    check("rst wr_data", 32'(wr_data), 32'h0);
    check("rst grant_id", 32'(grant_id), 32'h0);
    check("rst addr_err", 32'(addr_err), 32'h0);
    check("rst wr_count", 32'(wr_count), 32'h0);
    check("rst req_ready", 32'(req_ready), 32'h0);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive, check the combinational grant, queue the write-stage expectation, compare next cycle.
  task automatic cycle(input logic [2:0] v, input logic st, input logic [2:0] exp_rdy, input string tag);
    exp_t e;
    drive(v, st);
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
    e.en = '0; e.err = 1'b0; e.data = last_data_m; e.gid = last_gid_m; e.cnt = cnt_m;
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i] && v[i]) begin
        if (cur_addr[i] < 4'd8) begin
          e.en = 8'b1 << cur_addr[i];
          e.data = cur_data[i];
          e.gid = 3'(i);
          cnt_m = cnt_m + 16'd1;
          e.cnt = cnt_m;
          last_data_m = cur_data[i];
          last_gid_m = 3'(i);
          bank_m[cur_addr[i][2:0]] = cur_data[i];
          bank_w[cur_addr[i][2:0]] = 1'b1;
        end else begin
          e.err = 1'b1;
        end
        ptr_m = (i + 1) % 3;
        cur_data[i] = cur_data[i] + 16'h0101;
      end
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    check({tag, " wr_enable"}, 32'(wr_enable), 32'(e.en));
    check({tag, " wr_data"}, 32'(wr_data), 32'(e.data));
    check({tag, " grant_id"}, 32'(grant_id), 32'(e.gid));
    check({tag, " addr_err"}, 32'(addr_err), 32'(e.err));
    check({tag, " wr_count"}, 32'(wr_count), 32'(e.cnt));
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{3'b001, 1'b0, 4'd5, 4'd0, 4'd0, 16'hBEEF, 16'h0000, 16'h0000, 3'b001};
    tbl[1]  = '{3'b000, 1'b0, 4'd5, 4'd0, 4'd0, 16'hBEEF, 16'h0000, 16'h0000, 3'b000};
    tbl[2]  = '{3'b111, 1'b0, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h3333, 3'b010};
    tbl[3]  = '{3'b101, 1'b0, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h3333, 3'b100};
    tbl[4]  = '{3'b011, 1'b0, 4'd1, 4'd6, 4'd3, 16'h1111, 16'h6666, 16'h3333, 3'b001};
    tbl[5]  = '{3'b110, 1'b1, 4'd1, 4'd6, 4'd7, 16'h1111, 16'h6666, 16'h7777, 3'b000};
    tbl[6]  = '{3'b110, 1'b0, 4'd1, 4'd6, 4'd7, 16'h1111, 16'h6666, 16'h7777, 3'b010};
    tbl[7]  = '{3'b100, 1'b0, 4'd1, 4'd6, 4'd7, 16'h1111, 16'h6666, 16'h7777, 3'b100};
    tbl[8]  = '{3'b010, 1'b0, 4'd1, 4'd9, 4'd7, 16'h1111, 16'h9999, 16'h7777, 3'b010};
    tbl[9]  = '{3'b000, 1'b0, 4'd1, 4'd9, 4'd7, 16'h1111, 16'h9999, 16'h7777, 3'b000};
    tbl[10] = '{3'b111, 1'b0, 4'd3, 4'd3, 4'd3, 16'hA0A0, 16'hA1A1, 16'hA2A2, 3'b100};
    tbl[11] = '{3'b011, 1'b0, 4'd3, 4'd3, 4'd3, 16'hA0A0, 16'hA1A1, 16'hA2A2, 3'b001};
    tbl[12] = '{3'b010, 1'b0, 4'd3, 4'd3, 4'd3, 16'hA0A0, 16'hA1A1, 16'hA2A2, 3'b010};
    tbl[13] = '{3'b000, 1'b0, 4'd3, 4'd3, 4'd3, 16'hA0A0, 16'hA1A1, 16'hA2A2, 3'b000};

    for (int i = 0; i < 8; i++) begin
      bank_m[i] = '0;
      bank_w[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      cur_addr[i] = '0;
      cur_data[i] = '0;
    end
    reset_n = 1'b1;
    drive(3'b000, 1'b0);
    #3;
    do_reset();

    for (int r = 0; r < 14; r++) begin
      cur_addr[0] = tbl[r].a0; cur_addr[1] = tbl[r].a1; cur_addr[2] = tbl[r].a2;
      cur_data[0] = tbl[r].d0; cur_data[1] = tbl[r].d1; cur_data[2] = tbl[r].d2;
      cycle(tbl[r].v, tbl[r].st, tbl[r].rdy, $sformatf("vec%0d", r));
    end

    // Contention from reset, then a 3-cycle stall that must resume at the saved pointer.
    do_reset();
    cur_addr[0] = 4'd0; cur_addr[1] = 4'd1; cur_addr[2] = 4'd2;
    cur_data[0] = 16'h1000; cur_data[1] = 16'h2000; cur_data[2] = 16'h3000;
    for (int c = 0; c < 4; c++) cycle(3'b111, 1'b0, model_grant(3'b111, 1'b0, ptr_m), $sformatf("cont%0d", c));
    check("cont wr_count", 32'(wr_count), 32'd4);
    for (int c = 0; c < 3; c++) cycle(3'b111, 1'b1, model_grant(3'b111, 1'b1, ptr_m), $sformatf("stall%0d", c));
    cycle(3'b111, 1'b0, model_grant(3'b111, 1'b0, ptr_m), "resume");
    check("resume grant_id", 32'(grant_id), 32'd1);

    // Reset asserted while a transfer is pending: the write must be dropped.
    cur_addr[0] = 4'd4; cur_data[0] = 16'hDEAD;
    drive(3'b001, 1'b0);
    #1;
    check("midrst req_ready", 32'(req_ready), 32'h1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst wr_enable", 32'(wr_enable), 32'h0);
    check("midrst wr_data", 32'(wr_data), 32'h0);
    check("midrst wr_count", 32'(wr_count), 32'h0);
    @(negedge clk);
    check("midrst hold wr_enable", 32'(wr_enable), 32'h0);
    reset_n = 1'b1;
    model_reset();
    cur_addr[1] = 4'd1; cur_addr[2] = 4'd2;
    cycle(3'b111, 1'b0, 3'b001, "after_rst");

    // Counter wrap: run up to 0xFFFF with only requester 0, then one more write.
    cur_addr[0] = 4'd5; cur_data[0] = 16'h5A5A;
    n = 32'hFFFF - 32'(cnt_m);
    drive(3'b001, 1'b0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("wrap pre wr_count", 32'(wr_count), 32'hFFFF);
    cnt_m = 16'hFFFF; ptr_m = 1; last_data_m = 16'h5A5A; last_gid_m = 3'd0;
    bank_m[5] = 16'h5A5A; bank_w[5] = 1'b1;
    cur_data[0] = 16'hC0DE;
    cycle(3'b001, 1'b0, model_grant(3'b001, 1'b0, ptr_m), "wrap");
    check("wrap wr_count", 32'(wr_count), 32'h0);
    cycle(3'b000, 1'b0, 3'b000, "idle");
    #1;
    for (int i = 0; i < 8; i++) begin
      if (bank_w[i]) check($sformatf("bank reg%0d", i), 32'(dut_bank[i]), 32'(bank_m[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
